// File: rtl/riscv_cpu_pkg.sv
// Shared pipeline-control types: scoreboard entry, forwarding select and control FSM state.
package riscv_cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FwdNone = 2'd0,
    FwdEx   = 2'd1,
    FwdMem  = 2'd2,
    FwdWb   = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StExWait    = 2'd2,
    StMemWait   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } sb_entry_t;

  // An in-flight writer matches a source unless the source is x0 or unused.
  function automatic logic sb_match(input sb_entry_t             e,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic                  used);
    return e.valid & e.we & (e.rd == rs) & (rs != '0) & used;
  endfunction

endpackage

// File: rtl/pipeline_fwd_sel.sv
// Per-operand hazard resolver: picks the youngest in-flight writer of one source register
// and reports whether the operand must hold in ID.
module pipeline_fwd_sel
  import riscv_cpu_pkg::*;
#(
  parameter bit ForwardEn = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  rs_used_i,
  input  sb_entry_t             sb_ex_i,
  input  sb_entry_t             sb_mem_i,
  input  sb_entry_t             sb_wb_i,
  output fwd_sel_e              sel_o,
  output logic                  stall_o
);

  logic     hit_ex, hit_mem, hit_wb;
  fwd_sel_e sel;
  logic     src_is_load;

  assign hit_ex  = sb_match(sb_ex_i, rs_i, rs_used_i);
  assign hit_mem = sb_match(sb_mem_i, rs_i, rs_used_i);
  assign hit_wb  = sb_match(sb_wb_i, rs_i, rs_used_i);

  // Youngest writer wins.
  always_comb begin
    sel         = FwdNone;
    src_is_load = 1'b0;
    if (hit_ex) begin
      sel         = FwdEx;
      src_is_load = sb_ex_i.is_load;
    end else if (hit_mem) begin
      sel         = FwdMem;
      src_is_load = sb_mem_i.is_load;
    end else if (hit_wb) begin
      sel         = FwdWb;
      src_is_load = sb_wb_i.is_load;
    end
  end

  // With forwarding only a load still in EX must wait (its data first exists in MEM);
  // without forwarding any pending writer blocks the reader until it leaves WB.
  assign stall_o = ForwardEn ? ((sel == FwdEx) & src_is_load) : (sel != FwdNone);
  assign sel_o   = ForwardEn ? sel : FwdNone;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: scoreboard of EX/MEM/WB writers,
// per-stage stall/flush, EX operand forwarding selects and stall/flush perf counters.
// Build option: define PIPELINE_CTRL_FORWARDING_EN to enable operand forwarding; otherwise
// every RAW dependency stalls IF/ID until the writer has left WB.
module pipeline_ctrl
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_is_load_i,
  input  logic                  ex_busy_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_stall_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  stall_ex_o,
  output logic                  stall_mem_o,
  output logic                  flush_if_o,
  output logic                  flush_id_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic [PERF_W-1:0]     stall_cnt_o,
  output logic [PERF_W-1:0]     flush_cnt_o
);

`ifdef PIPELINE_CTRL_FORWARDING_EN
  localparam bit ForwardEn = 1'b1;
`else
  localparam bit ForwardEn = 1'b0;
`endif

  sb_entry_t   sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d, sb_wb_q, sb_wb_d;
  sb_entry_t   id_entry;
  ctrl_state_e state_q, state_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  fwd_sel_e    fwd_a_sel, fwd_b_sel;
  logic        hazard_a, hazard_b, raw_stall, branch_flush;

  assign id_entry = '{valid: id_valid_i, rd: id_rd_i, we: id_we_i, is_load: id_is_load_i};

  pipeline_fwd_sel #(
    .ForwardEn (ForwardEn)
  ) u_fwd_a (
    .rs_i      (id_rs1_i),
    .rs_used_i (id_valid_i & id_rs1_used_i),
    .sb_ex_i   (sb_ex_q),
    .sb_mem_i  (sb_mem_q),
    .sb_wb_i   (sb_wb_q),
    .sel_o     (fwd_a_sel),
    .stall_o   (hazard_a)
  );

  pipeline_fwd_sel #(
    .ForwardEn (ForwardEn)
  ) u_fwd_b (
    .rs_i      (id_rs2_i),
    .rs_used_i (id_valid_i & id_rs2_used_i),
    .sb_ex_i   (sb_ex_q),
    .sb_mem_i  (sb_mem_q),
    .sb_wb_i   (sb_wb_q),
    .sel_o     (fwd_b_sel),
    .stall_o   (hazard_b)
  );

  assign raw_stall   = hazard_a | hazard_b;
  assign fwd_a_sel_o = fwd_a_sel;
  assign fwd_b_sel_o = fwd_b_sel;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // Prioritised stall/flush decode and scoreboard advance.
  always_comb begin
    stall_if_o   = 1'b0;
    stall_id_o   = 1'b0;
    stall_ex_o   = 1'b0;
    stall_mem_o  = 1'b0;
    flush_if_o   = 1'b0;
    flush_id_o   = 1'b0;
    branch_flush = 1'b0;
    sb_ex_d      = sb_ex_q;
    sb_mem_d     = sb_mem_q;
    sb_wb_d      = sb_wb_q;
    state_d      = StRun;
    if (mem_stall_i) begin
      // Whole pipe freezes; a branch in EX is re-presented once memory is ready.
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      state_d     = StMemWait;
    end else if (ex_busy_i) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      stall_ex_o = 1'b1;
      sb_mem_d   = '0;
      sb_wb_d    = sb_mem_q;
      state_d    = StExWait;
    end else if (ex_branch_taken_i) begin
      // Branch wins over a RAW stall: the dependent instruction is on the wrong path.
      flush_if_o   = 1'b1;
      flush_id_o   = 1'b1;
      branch_flush = 1'b1;
      sb_ex_d      = '0;
      sb_mem_d     = sb_ex_q;
      sb_wb_d      = sb_mem_q;
    end else if (raw_stall) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_id_o = 1'b1;
      sb_ex_d    = '0;
      sb_mem_d   = sb_ex_q;
      sb_wb_d    = sb_mem_q;
      state_d    = StLoadStall;
    end else begin
      sb_ex_d  = id_valid_i ? id_entry : '0;
      sb_mem_d = sb_ex_q;
      sb_wb_d  = sb_mem_q;
    end
    stall_cnt_d = stall_cnt_q + PERF_W'(stall_id_o);
    flush_cnt_d = flush_cnt_q + PERF_W'(branch_flush);
  end

  // Scoreboard, state and perf counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_ex_q     <= '0;
      sb_mem_q    <= '0;
      sb_wb_q     <= '0;
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      sb_wb_q     <= sb_wb_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The debug-visible state must always trace back to the previous cycle's cause.
  mem_wait_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StMemWait) |-> $past(mem_stall_i));
  ex_wait_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StExWait) |-> $past(ex_busy_i));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: the driver pushes hand-computed expectations
// per cycle, a separate monitor pops and compares them on the falling edge.
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_we_i, id_is_load_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        ex_busy_i, ex_branch_taken_i, mem_stall_i;
  logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_if_o, flush_id_o;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(
    .PERF_W (32)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .id_valid_i        (id_valid_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .id_rd_i           (id_rd_i),
    .id_we_i           (id_we_i),
    .id_is_load_i      (id_is_load_i),
    .ex_busy_i         (ex_busy_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .mem_stall_i       (mem_stall_i),
    .stall_if_o        (stall_if_o),
    .stall_id_o        (stall_id_o),
    .stall_ex_o        (stall_ex_o),
    .stall_mem_o       (stall_mem_o),
    .flush_if_o        (flush_if_o),
    .flush_id_o        (flush_id_o),
    .fwd_a_sel_o       (fwd_a_sel_o),
    .fwd_b_sel_o       (fwd_b_sel_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       busy;
    logic       br;
    logic       ms;
  } in_t;

  typedef struct packed {
    logic [5:0]  fl;   // {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  localparam logic [5:0] S0 = 6'b000000;  // no stall, no flush
  localparam logic [5:0] LU = 6'b110001;  // RAW/load-use bubble
  localparam logic [5:0] BR = 6'b000011;  // taken-branch flush
  localparam logic [5:0] MS = 6'b111100;  // memory stall
  localparam logic [5:0] BZ = 6'b111000;  // EX busy

  exp_t        exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_sc  = 0;
  int unsigned m_fc  = 0;
  exp_t        mon_exp, mon_act;
  string       mon_name;

  function automatic in_t nop();
    in_t t = '0;
    return t;
  endfunction

  function automatic in_t alu(int rd, int rs1, int rs2);
    in_t t = '0;
    t.v   = 1'b1;
    t.rd  = 5'(rd);
    t.rs1 = 5'(rs1);
    t.rs2 = 5'(rs2);
    t.u1  = 1'b1;
    t.u2  = 1'b1;
    t.we  = 1'b1;
    return t;
  endfunction

  function automatic in_t ldi(int rd, int rs1);
    in_t t = '0;
    t.v   = 1'b1;
    t.rd  = 5'(rd);
    t.rs1 = 5'(rs1);
    t.u1  = 1'b1;
    t.we  = 1'b1;
    t.ld  = 1'b1;
    return t;
  endfunction

  function automatic in_t ctl(in_t t, logic busy, logic br, logic ms);
    in_t r = t;
    r.busy = busy;
    r.br   = br;
    r.ms   = ms;
    return r;
  endfunction

  task automatic apply(input in_t i);
    id_valid_i        = i.v;
    id_rs1_i          = i.rs1;
    id_rs2_i          = i.rs2;
    id_rs1_used_i     = i.u1;
    id_rs2_used_i     = i.u2;
    id_rd_i           = i.rd;
    id_we_i           = i.we;
    id_is_load_i      = i.ld;
    ex_busy_i         = i.busy;
    ex_branch_taken_i = i.br;
    mem_stall_i       = i.ms;
  endtask

  // One cycle: drive ID/EX/MEM inputs, queue the expected outputs, advance the counter model.
  task automatic step(input string nm, input in_t i, input logic [5:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    apply(i);
    e = '{fl: fl, fa: fa, fb: fb, sc: m_sc, fc: m_fc};
    exp_q.push_back(e);
    name_q.push_back(nm);
    m_sc += 32'(fl[4]);
    m_fc += 32'(fl[1]);
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    apply(nop());
    m_sc = 0;
    m_fc = 0;
    e = '{fl: S0, fa: 2'd0, fb: 2'd0, sc: 32'd0, fc: 32'd0};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = '{fl: {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_if_o, flush_id_o},
                     fa: fwd_a_sel_o, fb: fwd_b_sel_o, sc: stall_cnt_o, fc: flush_cnt_o};
        n_cmp++;
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: got fl=%b fa=%0d fb=%0d sc=%0d fc=%0d, want fl=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                   mon_name, mon_act.fl, mon_act.fa, mon_act.fb, mon_act.sc, mon_act.fc,
                   mon_exp.fl, mon_exp.fa, mon_exp.fb, mon_exp.sc, mon_exp.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    apply(nop());
    repeat (2) @(posedge clk_i);
    step("idle after reset", nop(), S0, 2'd0, 2'd0);
`ifdef PIPELINE_CTRL_FORWARDING_EN
    step("addi x5", alu(5, 1, 2), S0, 2'd0, 2'd0);
    step("fwd ex", alu(6, 5, 1), S0, 2'd1, 2'd0);
    repeat (3) step("drain", nop(), S0, 2'd0, 2'd0);
    step("addi x5 again", alu(5, 1, 2), S0, 2'd0, 2'd0);
    step("gap", nop(), S0, 2'd0, 2'd0);
    step("fwd mem", alu(6, 5, 1), S0, 2'd2, 2'd0);
    step("fwd wb", alu(7, 1, 5), S0, 2'd0, 2'd3);
    repeat (3) step("drain", nop(), S0, 2'd0, 2'd0);
    step("write x0", alu(0, 1, 2), S0, 2'd0, 2'd0);
    step("read x0", alu(8, 0, 0), S0, 2'd0, 2'd0);
    repeat (3) step("drain", nop(), S0, 2'd0, 2'd0);
    step("lw x7", ldi(7, 1), S0, 2'd0, 2'd0);
    step("load use", alu(8, 7, 7), LU, 2'd1, 2'd1);
    step("load fwd mem", alu(8, 7, 7), S0, 2'd2, 2'd2);
    repeat (3) step("stall cnt", nop(), S0, 2'd0, 2'd0);
    step("lw x9", ldi(9, 1), S0, 2'd0, 2'd0);
    step("branch over load use", ctl(alu(10, 9, 2), 1'b0, 1'b1, 1'b0), BR, 2'd1, 2'd0);
    repeat (3) step("flush cnt", nop(), S0, 2'd0, 2'd0);
    step("addi x11", alu(11, 1, 2), S0, 2'd0, 2'd0);
    repeat (3) step("mem stall masks branch", ctl(alu(12, 11, 1), 1'b0, 1'b1, 1'b1), MS, 2'd1, 2'd0);
    step("branch after mem stall", ctl(alu(12, 11, 1), 1'b0, 1'b1, 1'b0), BR, 2'd1, 2'd0);
    repeat (3) step("counters", nop(), S0, 2'd0, 2'd0);
    step("lw x13", ldi(13, 1), S0, 2'd0, 2'd0);
    repeat (4) step("ex busy", ctl(alu(14, 13, 13), 1'b1, 1'b0, 1'b0), BZ, 2'd1, 2'd1);
    step("load use after busy", alu(14, 13, 13), LU, 2'd1, 2'd1);
`else
    step("addi x5", alu(5, 1, 2), S0, 2'd0, 2'd0);
    repeat (3) step("raw stall", alu(6, 5, 1), LU, 2'd0, 2'd0);
    step("raw cleared", alu(6, 5, 1), S0, 2'd0, 2'd0);
    step("drain", nop(), S0, 2'd0, 2'd0);
    step("write x0", alu(0, 1, 2), S0, 2'd0, 2'd0);
    step("read x0", alu(8, 0, 0), S0, 2'd0, 2'd0);
    repeat (3) step("drain", nop(), S0, 2'd0, 2'd0);
    step("lw x7", ldi(7, 1), S0, 2'd0, 2'd0);
    repeat (3) step("raw load stall", alu(8, 7, 7), LU, 2'd0, 2'd0);
    step("raw load cleared", alu(8, 7, 7), S0, 2'd0, 2'd0);
    repeat (3) step("stall cnt", nop(), S0, 2'd0, 2'd0);
    step("lw x9", ldi(9, 1), S0, 2'd0, 2'd0);
    step("branch over raw", ctl(alu(10, 9, 2), 1'b0, 1'b1, 1'b0), BR, 2'd0, 2'd0);
    repeat (3) step("flush cnt", nop(), S0, 2'd0, 2'd0);
    step("addi x11", alu(11, 1, 2), S0, 2'd0, 2'd0);
    repeat (3) step("mem stall masks branch", ctl(alu(12, 11, 1), 1'b0, 1'b1, 1'b1), MS, 2'd0, 2'd0);
    step("branch after mem stall", ctl(alu(12, 11, 1), 1'b0, 1'b1, 1'b0), BR, 2'd0, 2'd0);
    repeat (3) step("counters", nop(), S0, 2'd0, 2'd0);
    step("lw x13", ldi(13, 1), S0, 2'd0, 2'd0);
    repeat (4) step("ex busy", ctl(alu(14, 13, 13), 1'b1, 1'b0, 1'b0), BZ, 2'd0, 2'd0);
    step("raw after busy", alu(14, 13, 13), LU, 2'd0, 2'd0);
`endif
    do_reset("reset mid stall");
    step("reader after reset", alu(14, 13, 13), S0, 2'd0, 2'd0);
    step("idle end", nop(), S0, 2'd0, 2'd0);
    repeat (3) @(negedge clk_i);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
